afifo_cmd_reader: RTL and testbench
===================================

# afifo_cmd_reader

Read-side consumer of the JTAG asynchronous FIFO. It runs in the system (read) clock domain, pops bytes from the FIFO, and assembles them into read/write commands. Each complete command is presented to the downstream bus master over a valid/ready handshake. It is the other end of the FIFO whose write side is fed from the TCK domain.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO byte width.
- ADDR_WIDTH, 32, command address width; must be a multiple of DATA_WIDTH.
- WORD_WIDTH, 32, write-data width; must be a multiple of DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, stall limit used only when the timeout feature is compiled in.

Ports:
- rclk  input  1  read-domain clock; one clock; all logic on its rising edge.
- r_nrst  input  1  reset; synchronous, active-low.
- empty  input  1  FIFO empty flag.
- rdata  input  DATA_WIDTH  FIFO head byte; valid whenever empty=0 (first-word fall-through).
- rinc  output  1  pop strobe; one byte consumed per rclk cycle it is high.
- cmd_valid  output  1  command available.
- cmd_ready  input  1  downstream accepts command.
- cmd_write  output  1  1=write, 0=read.
- cmd_addr  output  ADDR_WIDTH  command address.
- cmd_wdata  output  WORD_WIDTH  write data; 0 for reads.
- err_opcode  output  1  one-cycle pulse: illegal opcode byte dropped.
- err_timeout  output  1  one-cycle pulse: partial command aborted.

## Operation
- Command stream format:
  - First byte is the opcode: 0x01=READ, 0x02=WRITE, 0x00=NOP.
  - Then ADDR_WIDTH/DATA_WIDTH address bytes, least-significant byte first.
  - WRITE only: then WORD_WIDTH/DATA_WIDTH data bytes, LSB first.
- FSM states: IDLE, ADDR, DATA, ISSUE.
- rinc = (state ∈ {IDLE, ADDR, DATA}) && !empty. It is combinational and never high when empty=1 or in ISSUE.
- IDLE, on a pop:
  - 0x01: set cmd_write=0, clear cmd_wdata, go to ADDR.
  - 0x02: set cmd_write=1, go to ADDR.
  - 0x00: stay in IDLE; no output activity.
  - Any other value: pulse err_opcode the next cycle, stay in IDLE. The byte is consumed.
- ADDR: each pop writes rdata into cmd_addr byte lane [byte_cnt]. After the last lane: go to DATA if cmd_write=1, else to ISSUE. byte_cnt is cleared on every state change.
- DATA: same lane-fill into cmd_wdata; after the last lane, go to ISSUE.
- ISSUE: cmd_valid=1. cmd_addr, cmd_wdata and cmd_write are held stable while cmd_valid=1 && cmd_ready=0. When cmd_valid && cmd_ready, go to IDLE.
- While empty=1 in ADDR or DATA, the FSM waits with no change to byte_cnt or fields.

## Timing
- Reset values (r_nrst=0 at a rising edge):
  - state=IDLE, byte_cnt=0.
  - cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, err_opcode=0, err_timeout=0.
  - rinc=0 during reset.
- Reset mid-command: the partial command is discarded; bytes already popped are lost.
- Throughput: one byte per cycle with a non-empty FIFO.
- Latency: cmd_valid rises the cycle after the final byte pop.
  - READ: 5 pops, so cmd_valid is high in the 6th cycle.
  - WRITE: 9 pops, so cmd_valid is high in the 10th cycle.
- No prefetch: rinc=0 in ISSUE, including the handshake cycle. The first pop of the next command occurs in the cycle after acceptance at the earliest.
- cmd_ready high with cmd_valid=0 is ignored.
- byte_cnt width is clog2(max(ADDR_WIDTH, WORD_WIDTH)/DATA_WIDTH). It wraps to 0 on each state transition.

## Configuration
- Macro: AFIFO_CMD_READER_TIMEOUT_EN.
- Defined:
  - A stall counter counts consecutive cycles with state ∈ {ADDR, DATA} && empty=1.
  - The counter clears on any pop or state change.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, clear byte_cnt and fields, pulse err_timeout for one cycle.
- Undefined: no counter; the FSM waits indefinitely; err_timeout is tied to 0. The port is always present.

## Structure
- jtag_types_pkg holds:
  - typedef enum logic [1:0] for the FSM states.
  - Opcode constants OP_NOP, OP_READ, OP_WRITE.
- Sub-module afifo_rd_timer holds the saturating stall counter with clear/enable inputs and an expire output. It is instantiated only under AFIFO_CMD_READER_TIMEOUT_EN.
- Bench drives signals through the TB modport of afifo_if with the read side only; the write side is left idle.

## Test plan
- Reset: r_nrst=0 for 2 cycles with empty=0, rdata=0x01 -> rinc=0, all outputs 0.
- READ, cmd_ready=1: bytes 01 EF BE AD DE -> cmd_valid for exactly 1 cycle, 6th cycle; cmd_write=0, cmd_addr=0xDEADBEEF, cmd_wdata=0.
- WRITE with backpressure: bytes 02 00 10 00 80 78 56 34 12, cmd_ready low for 3 cycles -> cmd_addr=0x80001000, cmd_wdata=0x12345678 held stable; rinc=0 until one cycle after acceptance.
- Illegal opcode and NOP: bytes 7F 00 01 04 00 00 00 -> err_opcode pulse once; NOP ignored; READ addr=0x00000004.
- Empty gaps: READ bytes with empty=1 for 5 cycles between each byte -> rinc never high while empty; correct address; no err pulses.
- Timeout (macro on, TIMEOUT_CYCLES=16): bytes 02 11 22 then empty -> err_timeout pulse, state IDLE; the following byte 0x01 is parsed as a new READ opcode.

Source files
------------

// File: rtl/jtag_types_pkg.sv
// Shared types for the JTAG async-FIFO command path: reader FSM states and opcode bytes.
package jtag_types_pkg;

    localparam int unsigned OPCODE_W = 8;

    localparam logic [OPCODE_W-1:0] OP_NOP   = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_READ  = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_WRITE = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ISSUE = 2'd3
    } rd_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/afifo_if.sv
// Read-side view of the JTAG async FIFO; the write side lives in the TCK domain and is not modelled here.
interface afifo_if #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic rclk
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;

    modport tb (input rclk, input rinc, output empty, output rdata);
    modport rd (input rclk, input empty, input rdata, output rinc);
endinterface

// File: rtl/afifo_rd_timer.sv
// Saturating stall counter; expire_c flags that the count has reached LIMIT-1.
module afifo_rd_timer #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);
    localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign expire_c = (cnt_q == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/afifo_cmd_reader.sv
// Pops opcode/address/data bytes from the JTAG async FIFO and issues bus commands over valid/ready.
// Stall timeout is compiled in with AFIFO_CMD_READER_TIMEOUT_EN.
module afifo_cmd_reader
    import jtag_types_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  rclk,
    input  logic                  r_nrst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [WORD_WIDTH-1:0] cmd_wdata,
    output logic                  err_opcode,
    output logic                  err_timeout
);
    localparam int unsigned ADDR_BYTES = ADDR_WIDTH / DATA_WIDTH;
    localparam int unsigned WORD_BYTES = WORD_WIDTH / DATA_WIDTH;
    localparam int unsigned MAX_BYTES  = max_u(ADDR_BYTES, WORD_BYTES);
    localparam int unsigned CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    if ((ADDR_WIDTH % DATA_WIDTH) != 0 || (WORD_WIDTH % DATA_WIDTH) != 0 ||
        DATA_WIDTH < OPCODE_W || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("afifo_cmd_reader: unsupported parameter set");
    end

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q;
    logic             pop_c, stall_c, abort_c, timeout_c, accept_c;
    logic             last_addr_c, last_data_c;
    logic             is_read_c, is_write_c, is_nop_c;

    // Pops are gated by reset so nothing is consumed while the FSM is being cleared.
    assign pop_c       = r_nrst && !empty && (state_q != ST_ISSUE);
    assign rinc        = pop_c;
    assign stall_c     = empty && ((state_q == ST_ADDR) || (state_q == ST_DATA));
    assign abort_c     = stall_c && timeout_c;
    assign accept_c    = cmd_valid && cmd_ready;
    assign last_addr_c = (byte_cnt_q == CNT_W'(ADDR_BYTES - 1));
    assign last_data_c = (byte_cnt_q == CNT_W'(WORD_BYTES - 1));
    assign is_read_c   = (rdata == DATA_WIDTH'(OP_READ));
    assign is_write_c  = (rdata == DATA_WIDTH'(OP_WRITE));
    assign is_nop_c    = (rdata == DATA_WIDTH'(OP_NOP));

`ifdef AFIFO_CMD_READER_TIMEOUT_EN
    logic state_chg_c;
    assign state_chg_c = (state_d != state_q);

    afifo_rd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (rclk),
        .rst_n    (r_nrst),
        .clr      (pop_c || state_chg_c || !stall_c),
        .en       (stall_c),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_c && (is_read_c || is_write_c)) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (abort_c)                   state_d = ST_IDLE;
                else if (pop_c && last_addr_c) state_d = cmd_write ? ST_DATA : ST_ISSUE;
            end
            ST_DATA: begin
                if (abort_c)                   state_d = ST_IDLE;
                else if (pop_c && last_data_c) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (accept_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!r_nrst) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            cmd_valid   <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid   <= (state_d == ST_ISSUE);
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;

            if (state_d != state_q)                                      byte_cnt_q <= '0;
            else if (pop_c && (state_q == ST_ADDR || state_q == ST_DATA)) byte_cnt_q <= byte_cnt_q + CNT_W'(1);

            if (pop_c && state_q == ST_IDLE) begin
                if (is_read_c) begin
                    cmd_write <= 1'b0;
                    cmd_wdata <= '0;
                end else if (is_write_c) begin
                    cmd_write <= 1'b1;
                end else if (!is_nop_c) begin
                    err_opcode <= 1'b1;
                end
            end

            // Little-endian lane fill, one byte per pop.
            if (pop_c && state_q == ST_ADDR) begin
                for (int unsigned i = 0; i < ADDR_BYTES; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) cmd_addr[i*DATA_WIDTH +: DATA_WIDTH] <= rdata;
                end
            end
            if (pop_c && state_q == ST_DATA) begin
                for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) cmd_wdata[i*DATA_WIDTH +: DATA_WIDTH] <= rdata;
                end
            end

            if (abort_c) begin
                cmd_write   <= 1'b0;
                cmd_addr    <= '0;
                cmd_wdata   <= '0;
                err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_afifo_cmd_reader.sv
// Directed, table-driven bench for afifo_cmd_reader; timeout sequence adapts to AFIFO_CMD_READER_TIMEOUT_EN.
module tb_afifo_cmd_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned WW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          r_nrst;
    logic          cmd_ready;
    logic          cmd_valid, cmd_write, err_opcode, err_timeout;
    logic [AW-1:0] cmd_addr;
    logic [WW-1:0] cmd_wdata;

    always #5 clk = ~clk;

    afifo_if #(.DATA_WIDTH(DW)) aif (.rclk(clk));

    afifo_cmd_reader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .WORD_WIDTH     (WW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .rclk        (clk),
        .r_nrst      (r_nrst),
        .empty       (aif.empty),
        .rdata       (aif.rdata),
        .rinc        (aif.rinc),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .err_opcode  (err_opcode),
        .err_timeout (err_timeout)
    );

    typedef struct {
        logic        nrst;
        logic        empty;
        logic [7:0]  rdata;
        logic        ready;
        logic        rinc;
        logic        valid;
        logic        err_op;
        logic        chk;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic nrst, input logic empty, input logic [7:0] rdata, input logic ready,
                       input logic rinc, input logic valid, input logic err_op, input logic chk,
                       input logic write, input logic [31:0] addr, input logic [31:0] wdata);
        vec_t v;
        v.nrst = nrst; v.empty = empty; v.rdata = rdata; v.ready = ready;
        v.rinc = rinc; v.valid = valid; v.err_op = err_op; v.chk = chk;
        v.write = write; v.addr = addr; v.wdata = wdata;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic nrst, input logic empty, input logic [7:0] rdata, input logic ready);
        @(negedge clk);
        r_nrst    = nrst;
        aif.empty = empty;
        aif.rdata = rdata;
        cmd_ready = ready;
        #1;
    endtask

    task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic ok;
        n_vec++;
        ok = (aif.rinc === v.rinc) && (cmd_valid === v.valid) && (err_opcode === v.err_op) &&
             (err_timeout === 1'b0);
        if (v.chk) ok = ok && (cmd_write === v.write) && (cmd_addr === v.addr) && (cmd_wdata === v.wdata);
        if (!ok) begin
            n_bad++;
            $display("FAIL vec%0d: rinc=%b valid=%b eop=%b eto=%b wr=%b addr=%h wdata=%h; expected rinc=%b valid=%b eop=%b eto=0 wr=%b addr=%h wdata=%h (fields checked=%b)",
                     idx, aif.rinc, cmd_valid, err_opcode, err_timeout, cmd_write, cmd_addr, cmd_wdata,
                     v.rinc, v.valid, v.err_op, v.write, v.addr, v.wdata, v.chk);
        end
    endtask

    initial begin
        logic [7:0] gap_bytes [5];
        bit         seen;
        bit         rinc_bad;
        int         at;

        r_nrst    = 1'b0;
        aif.empty = 1'b0;
        aif.rdata = 8'h01;
        cmd_ready = 1'b0;

        // Reset held two cycles with a READ opcode at the FIFO head.
        add(0, 0, 8'h01, 0,  0, 0, 0, 1, 0, 32'h0, 32'h0);
        add(0, 0, 8'h01, 0,  0, 0, 0, 1, 0, 32'h0, 32'h0);

        // READ 0xDEADBEEF with ready high: valid in the 6th cycle for one cycle.
        add(1, 0, 8'h01, 1,  1, 0, 0, 1, 0, 32'h0, 32'h0);
        add(1, 0, 8'hEF, 1,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'hBE, 1,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'hAD, 1,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'hDE, 1,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 1, 8'h00, 1,  0, 1, 0, 1, 0, 32'hDEADBEEF, 32'h0);
        add(1, 1, 8'h00, 1,  0, 0, 0, 0, 0, 32'h0, 32'h0);

        // WRITE with 3 cycles of backpressure; FIFO stays non-empty but no pop until after acceptance.
        add(1, 0, 8'h02, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h10, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h80, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h78, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h56, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h34, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h12, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) add(1, 0, 8'h00, 0,  0, 1, 0, 1, 1, 32'h80001000, 32'h12345678);
        add(1, 0, 8'h00, 1,  0, 1, 0, 1, 1, 32'h80001000, 32'h12345678);
        add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 1, 8'h00, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Illegal opcode, NOP, then READ 0x00000004 (clears write flag and wdata).
        add(1, 0, 8'h7F, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h00, 0,  1, 0, 1, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h01, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h04, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h00, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 1, 8'h00, 1,  0, 1, 0, 1, 0, 32'h00000004, 32'h0);
        add(1, 1, 8'h00, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0);

        // READ 0x12345678 with 5 empty cycles after every byte; stray ready is ignored while idle/filling.
        gap_bytes = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        for (int b = 0; b < 5; b++) begin
            add(1, 0, gap_bytes[b], (b != 4),  1, 0, 0, 0, 0, 32'h0, 32'h0);
            for (int g = 0; g < 5; g++) add(1, 1, 8'hA5, (b != 4),  0, (b == 4), 0, 0, 0, 32'h0, 32'h0);
        end
        add(1, 1, 8'h00, 1,  0, 1, 0, 1, 0, 32'h12345678, 32'h0);
        add(1, 1, 8'h00, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0);

        // Reset mid-command discards the partial WRITE.
        add(1, 0, 8'h02, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h11, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 0, 8'h22, 0,  1, 0, 0, 0, 0, 32'h0, 32'h0);
        add(0, 0, 8'h33, 0,  0, 0, 0, 0, 0, 32'h0, 32'h0);
        add(1, 1, 8'h00, 0,  0, 0, 0, 1, 0, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].nrst, vecs[i].empty, vecs[i].rdata, vecs[i].ready);
            check_vec(i, vecs[i]);
        end

        // Partial WRITE followed by a long stall.
        drive(1, 0, 8'h02, 0);
        drive(1, 0, 8'h11, 0);
        drive(1, 0, 8'h22, 0);
        seen = 1'b0; rinc_bad = 1'b0; at = 0;
`ifdef AFIFO_CMD_READER_TIMEOUT_EN
        for (int i = 1; i <= 40 && !seen; i++) begin
            drive(1, 1, 8'h5A, 0);
            if (aif.rinc) rinc_bad = 1'b1;
            if (err_timeout === 1'b1) begin
                seen = 1'b1;
                at   = i;
                chk1("timeout_addr_cleared", cmd_addr, 32'h0);
                chk1("timeout_write_cleared", 32'(cmd_write), 32'h0);
            end
        end
        chk1("timeout_seen", 32'(seen), 32'h1);
        chk1("timeout_cycle", 32'(at), 32'd17);
        chk1("stall_no_rinc", 32'(rinc_bad), 32'h0);
        drive(1, 1, 8'h00, 0);
        chk1("timeout_pulse_width", 32'(err_timeout), 32'h0);
        drive(1, 0, 8'h01, 1); chk1("after_timeout_pop_opcode", 32'(aif.rinc), 32'h1);
        drive(1, 0, 8'hEF, 1);
        drive(1, 0, 8'hBE, 1);
        drive(1, 0, 8'hAD, 1);
        drive(1, 0, 8'hDE, 1);
        drive(1, 1, 8'h00, 1);
        chk1("after_timeout_valid", 32'(cmd_valid), 32'h1);
        chk1("after_timeout_write", 32'(cmd_write), 32'h0);
        chk1("after_timeout_addr", cmd_addr, 32'hDEADBEEF);
`else
        for (int i = 1; i <= 40; i++) begin
            drive(1, 1, 8'h5A, 0);
            if (aif.rinc) rinc_bad = 1'b1;
            if (err_timeout !== 1'b0 || cmd_valid !== 1'b0) seen = 1'b1;
        end
        chk1("stall_no_timeout", 32'(seen), 32'h0);
        chk1("stall_no_rinc", 32'(rinc_bad), 32'h0);
        drive(1, 0, 8'h33, 0);
        drive(1, 0, 8'h44, 0);
        drive(1, 0, 8'h78, 0);
        drive(1, 0, 8'h56, 0);
        drive(1, 0, 8'h34, 0);
        drive(1, 0, 8'h12, 0);
        drive(1, 1, 8'h00, 1);
        chk1("resume_valid", 32'(cmd_valid), 32'h1);
        chk1("resume_write", 32'(cmd_write), 32'h1);
        chk1("resume_addr", cmd_addr, 32'h44332211);
        chk1("resume_wdata", cmd_wdata, 32'h12345678);
`endif
        drive(1, 1, 8'h00, 0);
        chk1("final_idle_valid", 32'(cmd_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
